// File: rtl/readout_rx_state_decision_bin_counter.sv
// Readout RX state-decision bin counter: counts valid samples up/down against a signed
// threshold from a midpoint and strobes the final count after NUM_SAMPLES accepted samples.
module readout_rx_state_decision_bin_counter #(
    parameter int                               SAMPLE_WIDTH      = 16,
    parameter logic signed [SAMPLE_WIDTH-1:0]   SAMPLE_THRESHOLD  = '0,
    parameter int                               BIN_COUNTER_WIDTH = 16,
    parameter int                               NUM_SAMPLES       = 1024,
    parameter int                               SAMPLE_CNT_WIDTH  = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start_in,
    input  logic                         valid_sample_in,
    input  logic [SAMPLE_WIDTH-1:0]      sample_in,
    output logic                         busy_out,
    output logic [BIN_COUNTER_WIDTH-1:0] bin_count_out,
    output logic                         finish_count_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [BIN_COUNTER_WIDTH-1:0] MIDPOINT   = {1'b1, {(BIN_COUNTER_WIDTH-1){1'b0}}};
    localparam logic [SAMPLE_CNT_WIDTH-1:0]  LAST_INDEX = SAMPLE_CNT_WIDTH'(NUM_SAMPLES - 1);

    state_t                         r_state;
    logic [BIN_COUNTER_WIDTH-1:0]   r_bin;
    logic [SAMPLE_CNT_WIDTH-1:0]    r_cnt;
    logic                           r_busy;
    logic                           r_finish;

    state_t                         w_state_nxt;
    logic [BIN_COUNTER_WIDTH-1:0]   w_bin_nxt;
    logic [SAMPLE_CNT_WIDTH-1:0]    w_cnt_nxt;
    logic                           w_up;

    assign w_up = $signed(sample_in) >= SAMPLE_THRESHOLD;

    always_comb begin
        w_state_nxt = r_state;
        w_bin_nxt   = r_bin;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                // A sample arriving together with start_in is deliberately not counted.
                if (start_in) begin
                    w_state_nxt = COUNT;
                    w_bin_nxt   = MIDPOINT;
                    w_cnt_nxt   = '0;
                end
            end
            COUNT: begin
                if (valid_sample_in) begin
                    if (w_up) begin
                        if (r_bin != '1) w_bin_nxt = r_bin + 1'b1;
                    end else begin
                        if (r_bin != '0) w_bin_nxt = r_bin - 1'b1;
                    end
                    w_cnt_nxt = r_cnt + 1'b1;
                    if (r_cnt == LAST_INDEX) w_state_nxt = FINISH;
                end
            end
            FINISH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_bin    <= MIDPOINT;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_finish <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bin    <= w_bin_nxt;
            r_cnt    <= w_cnt_nxt;
            r_busy   <= (w_state_nxt != IDLE);
            r_finish <= (w_state_nxt == FINISH);
        end
    end

    assign busy_out         = r_busy;
    assign bin_count_out    = r_bin;
    assign finish_count_out = r_finish;

endmodule
